// File: rtl/bus_mem_tgt.sv
// Word-organised memory target on a four-phase req/ack bus with WAIT_STATES response delay.
// Optional macro SKYWAVE_BUSTGT_ERR_EN adds err_o and out-of-window error responses.
module bus_mem_tgt #(
  parameter int unsigned AD_LEN      = 32,
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned BASE        = 0,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AD_LEN-1:0]    ad_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 ack_o,
  output logic                 busy_o
`ifdef SKYWAVE_BUSTGT_ERR_EN
  ,
  output logic                 err_o
`endif
);

  localparam int unsigned BYTES   = BUS_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam bit          NO_WAIT = (WAIT_STATES == 0);
  localparam logic [AD_LEN:0] WIN_LO = (AD_LEN+1)'(BASE);
  localparam logic [AD_LEN:0] WIN_HI =
    (AD_LEN+1)'(longint'(BASE) + longint'(DEPTH) * longint'(BYTES));

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_ack;
  logic                 r_busy;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_we;
  logic [IDX_W-1:0]     r_idx;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic [BUS_WIDTH-1:0] r_mem [DEPTH];

  logic                 w_in_win;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_wr_en;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [BUS_WIDTH-1:0] w_wr_data;

  // One extra top bit keeps the window limit from overflowing at the top of the address space.
  assign w_in_win = ({1'b0, ad_i} >= WIN_LO) && ({1'b0, ad_i} < WIN_HI);
  assign w_idx    = IDX_W'((ad_i - AD_LEN'(BASE)) >> OFF_W);

  // With no wait states the write lands on the accepting edge, straight from the bus inputs.
  assign w_wr_en   = reset_i &&
                     ((NO_WAIT && r_state == ST_IDLE && req_i && w_in_win && we_i) ||
                      (r_state == ST_WAIT && r_cnt == 4'd1 && r_we));
  assign w_wr_idx  = (r_state == ST_IDLE) ? w_idx  : r_idx;
  assign w_wr_data = (r_state == ST_IDLE) ? data_i : r_wdata;

  // NOTE: the array has no reset branch; clearing it would turn it into flops and it is not required.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

`ifdef SKYWAVE_BUSTGT_ERR_EN
  logic r_err;
  assign err_o = r_err;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
`ifdef SKYWAVE_BUSTGT_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef SKYWAVE_BUSTGT_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (req_i && w_in_win) begin
            r_we    <= we_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
            r_cnt   <= 4'(WAIT_STATES);
            r_busy  <= 1'b1;
            if (NO_WAIT) begin
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
              if (!we_i) r_data <= r_mem[w_idx];
            end else begin
              r_state <= ST_WAIT;
            end
          end
`ifdef SKYWAVE_BUSTGT_ERR_EN
          else if (req_i) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b1;
          end
`endif
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            if (!r_we) r_data <= r_mem[r_idx];
          end
        end
        ST_RESP: r_state <= ST_HOLD;
        ST_HOLD: begin
          if (!req_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_o = r_data;
  assign ack_o  = r_ack;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_bus_mem_tgt.sv
// Bench for bus_mem_tgt: two instances (BASE=0/WAIT_STATES=2 and BASE=0x1000/WAIT_STATES=0)
// driven by a vector table, reset and random sequences, checked against an array-based memory model.
module tb_bus_mem_tgt;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req  [2];
  logic        we   [2];
  logic [31:0] ad   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        busy [2];
`ifdef SKYWAVE_BUSTGT_ERR_EN
  logic        err  [2];
`endif

  int unsigned base_a [2] = '{32'h0, 32'h1000};
  int          ws     [2] = '{2, 0};

  logic [31:0] mdl  [2][256];
  bit          mvld [2][256];
  logic [31:0] last [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bus_mem_tgt #(.AD_LEN(32), .BUS_WIDTH(32), .BASE(0), .DEPTH(256), .WAIT_STATES(2)) u_a (
    .clk_i(clk), .reset_i(reset_n), .req_i(req[0]), .we_i(we[0]), .ad_i(ad[0]),
    .data_i(din[0]), .data_o(dout[0]), .ack_o(ack[0]), .busy_o(busy[0])
`ifdef SKYWAVE_BUSTGT_ERR_EN
    , .err_o(err[0])
`endif
  );

  bus_mem_tgt #(.AD_LEN(32), .BUS_WIDTH(32), .BASE(32'h1000), .DEPTH(256), .WAIT_STATES(0)) u_b (
    .clk_i(clk), .reset_i(reset_n), .req_i(req[1]), .we_i(we[1]), .ad_i(ad[1]),
    .data_i(din[1]), .data_o(dout[1]), .ack_o(ack[1]), .busy_o(busy[1])
`ifdef SKYWAVE_BUSTGT_ERR_EN
    , .err_o(err[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input int s, input logic [31:0] a);
    return (a >= base_a[s]) && (a < base_a[s] + 32'd1024);
  endfunction

  // One full four-phase transaction; the model decides latency, data and handshake timing.
  task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit use_exp, input logic [31:0] exp_d);
    bit          inwin;
    bit          expect_ack;
    bit          busy_ok;
    int          lat;
    int          extra;
    int          idx;
    logic [31:0] want;
    inwin   = in_win(s, a);
    idx     = int'(((a - base_a[s]) >> 2) & 32'hFF);
    busy_ok = 1'b1;
    lat     = 0;
    extra   = 0;
`ifdef SKYWAVE_BUSTGT_ERR_EN
    expect_ack = 1'b1;
`else
    expect_ack = inwin;
`endif
    we[s] = w; ad[s] = a; din[s] = d; req[s] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack[s]) begin
        lat = i;
        break;
      end
      if (busy[s] !== inwin) busy_ok = 1'b0;
    end
    if (!expect_ack) begin
      check("oow_no_ack", lat, 0);
      check("oow_busy_low", busy_ok, 1);
      check("oow_data_kept", dout[s], last[s]);
      req[s] = 1'b0;
      @(negedge clk);
      return;
    end
    check("ack_latency", lat, inwin ? ws[s] + 1 : 1);
    check("busy_before_ack", busy_ok, 1);
    if (inwin && !w) begin
      want    = use_exp ? exp_d : mdl[s][idx];
      last[s] = want;
    end else begin
      want = last[s];
    end
    check(w ? "data_o_on_write" : "read_data", dout[s], want);
`ifdef SKYWAVE_BUSTGT_ERR_EN
    check("err_o", err[s], !inwin);
`endif
    if (inwin && w) begin
      mdl[s][idx]  = d;
      mvld[s][idx] = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack[s]) extra++;
      if (!busy[s]) busy_ok = 1'b0;
    end
    if (hold > 0) begin
      check("single_ack_held_req", extra, 0);
      check("busy_while_held", busy_ok, 1);
    end
    req[s] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!busy[s]) begin
        lat = i;
        break;
      end
    end
    check("busy_drop_cycles", lat, (hold == 0) ? 2 : 1);
    check("data_o_stable", dout[s], want);
  endtask

  typedef struct {
    int          s;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [13];

  int          rs;
  int          ridx;
  bit          rw;
  logic [31:0] ra;

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h10,   32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h10,   32'h0,        0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1'b0, 32'h13,   32'h0,        5, 32'hDEADBEEF};
    vecs[3]  = '{0, 1'b1, 32'h20,   32'h0BADF00D, 1, 32'h0};
    vecs[4]  = '{1, 1'b1, 32'h1000, 32'h11112222, 0, 32'h0};
    vecs[5]  = '{1, 1'b0, 32'h1000, 32'h0,        2, 32'h11112222};
    vecs[6]  = '{1, 1'b1, 32'h13FC, 32'hA5A55A5A, 0, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'h13FE, 32'h0,        0, 32'hA5A55A5A};
    vecs[8]  = '{1, 1'b0, 32'h1400, 32'h0,        0, 32'h0};
    vecs[9]  = '{1, 1'b0, 32'h0FFC, 32'h0,        0, 32'h0};
    vecs[10] = '{0, 1'b0, 32'h400,  32'h0,        0, 32'h0};
    vecs[11] = '{0, 1'b1, 32'h3FC,  32'hCAFEF00D, 3, 32'h0};
    vecs[12] = '{0, 1'b0, 32'h3FC,  32'h0,        0, 32'hCAFEF00D};

    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; ad[s] = '0; din[s] = '0; last[s] = '0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_ack", ack[s], 0);
      check("reset_busy", busy[s], 0);
      check("reset_data", dout[s], 0);
`ifdef SKYWAVE_BUSTGT_ERR_EN
      check("reset_err", err[s], 0);
`endif
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++)
      txn(vecs[v].s, vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].hold,
          !vecs[v].we, vecs[v].exp_d);

    // Reset during WAIT of a write must drop the write and idle all outputs.
    we[0] = 1'b1; ad[0] = 32'h20; din[0] = 32'h12345678; req[0] = 1'b1;
    @(negedge clk);
    check("mid_wait_busy", busy[0], 1);
    check("mid_wait_ack", ack[0], 0);
    reset_n = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("midreset_ack", ack[s], 0);
      check("midreset_busy", busy[s], 0);
      check("midreset_data", dout[s], 0);
`ifdef SKYWAVE_BUSTGT_ERR_EN
      check("midreset_err", err[s], 0);
`endif
      last[s] = '0;
    end
    reset_n = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b1, 32'h0BADF00D);

    for (int k = 0; k < 40; k++) begin
      rs   = int'($urandom_range(1, 0));
      ridx = int'($urandom_range(255, 0));
      rw   = 1'($urandom_range(1, 0));
      ra   = base_a[rs] + 32'(ridx) * 32'd4 + 32'($urandom_range(3, 0));
      if (!mvld[rs][ridx]) rw = 1'b1;
      txn(rs, rw, ra, $urandom, int'($urandom_range(3, 0)), 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
